// File: rtl/mem_io_pkg.sv
// Shared constants and helpers for the CPU memory/I-O responder.
package mem_io_pkg;

  localparam logic [17:0] IO_RXTX_ADDR = 18'h30000;
  localparam logic [17:0] IO_CLK_ADDR  = 18'h30004;
  localparam logic [1:0]  IO_SEL       = 2'b11;

  typedef enum logic {
    SRC_IO  = 1'b0,
    SRC_RAM = 1'b1
  } rd_src_e;

  function automatic logic [7:0] snap_byte(input logic [31:0] snap, input logic [1:0] idx);
    return snap[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Show-ahead byte FIFO with registered almost-full flag.
module byte_fifo #(
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = DEPTH - 2,
  localparam int AW         = $clog2(DEPTH),
  localparam int CW         = AW + 1
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count,
  output logic          afull
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          afull_q, afull_d;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  // A pop in the same cycle frees the slot, so a push into a full queue still lands.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    afull_d = (count_d >= CW'(AFULL_LEVEL));
  end

  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      afull_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      afull_q  <= afull_d;
    end
  end

  assign head  = mem[rd_ptr_q];
  assign count = count_q;
  assign afull = afull_q;

endmodule

// File: rtl/mem_io_responder.sv
// Byte-wide memory bus responder: sync RAM plus an I/O window with UART TX/RX,
// free-running cycle counter with snapshot, and a sticky stop flag.
module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int RAM_ADDR_W = 17,
  parameter int TX_DEPTH   = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        program_done
);

  localparam int CW = $clog2(TX_DEPTH) + 1;

  logic [17:0] addr;
  logic        is_io, io_rd, io_wr, ram_we, ram_re;
  logic [RAM_ADDR_W-1:0] ram_addr;

  assign addr     = mem_a[17:0];
  assign ram_addr = mem_a[RAM_ADDR_W-1:0];
  assign is_io    = (addr[17:16] == IO_SEL);
  assign io_rd    = !mem_wr && is_io;
  assign io_wr    = mem_wr && is_io;
  assign ram_we   = mem_wr && !is_io && !rst_in;
  assign ram_re   = !mem_wr && !is_io && !rst_in;

  // RAM: read data registered only on RAM reads so it holds across writes and I/O reads.
  logic [7:0] ram [2**RAM_ADDR_W];
  logic [7:0] ram_rd_q;

  always_ff @(posedge clk_in) begin
    if (ram_we) ram[ram_addr] <= mem_dout;
    if (ram_re) ram_rd_q <= ram[ram_addr];
  end

  logic [31:0] counter_q, counter_d;
  logic [31:0] snap_q, snap_d;
  logic        rx_full_q, rx_full_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic [7:0]  io_rd_q, io_rd_d;
  rd_src_e     src_q, src_d;
  logic        done_q, done_d;
  logic [7:0]  io_rd_byte;
  logic        rx_pop, rx_cap, tx_push, tx_pop;
  logic [7:0]  tx_push_data;

  always_comb begin
    io_rd_byte = 8'h00;
    case (addr)
      IO_RXTX_ADDR:         io_rd_byte = rx_full_q ? rx_byte_q : 8'h00;
      IO_CLK_ADDR:          io_rd_byte = counter_q[7:0];
      IO_CLK_ADDR + 18'd1:  io_rd_byte = snap_byte(snap_q, 2'd1);
      IO_CLK_ADDR + 18'd2:  io_rd_byte = snap_byte(snap_q, 2'd2);
      IO_CLK_ADDR + 18'd3:  io_rd_byte = snap_byte(snap_q, 2'd3);
      default:              io_rd_byte = 8'h00;
    endcase
  end

  always_comb begin
    rx_pop       = io_rd && (addr == IO_RXTX_ADDR);
    rx_cap       = rx_valid && !rx_full_q;
    tx_push      = io_wr && ((addr == IO_RXTX_ADDR && mem_dout != 8'h00) || addr == IO_CLK_ADDR);
    tx_push_data = (addr == IO_CLK_ADDR) ? 8'h00 : mem_dout;

    counter_d = counter_q + 32'd1;
    snap_d    = (io_rd && addr == IO_CLK_ADDR) ? counter_q : snap_q;
    done_d    = done_q || (io_wr && addr == IO_CLK_ADDR);

    // A capture can only happen while empty, so it never collides with a real pop.
    rx_full_d = rx_full_q;
    rx_byte_d = rx_byte_q;
    if (rx_cap) begin
      rx_full_d = 1'b1;
      rx_byte_d = rx_data;
    end else if (rx_pop) begin
      rx_full_d = 1'b0;
    end

    src_d   = src_q;
    io_rd_d = io_rd_q;
    if (!mem_wr) src_d = is_io ? SRC_IO : SRC_RAM;
    if (io_rd)   io_rd_d = io_rd_byte;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      counter_q <= '0;
      snap_q    <= '0;
      rx_full_q <= 1'b0;
      rx_byte_q <= '0;
      io_rd_q   <= '0;
      src_q     <= SRC_IO;
      done_q    <= 1'b0;
    end else begin
      counter_q <= counter_d;
      snap_q    <= snap_d;
      rx_full_q <= rx_full_d;
      rx_byte_q <= rx_byte_d;
      io_rd_q   <= io_rd_d;
      src_q     <= src_d;
      done_q    <= done_d;
    end
  end

  logic          tx_empty, tx_full;
  logic [CW-1:0] tx_count;

  assign tx_pop = !tx_empty && tx_ready;

  byte_fifo #(
    .DEPTH       (TX_DEPTH),
    .AFULL_LEVEL (TX_DEPTH - 2)
  ) u_tx_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (tx_push),
    .push_data (tx_push_data),
    .pop       (tx_pop),
    .head      (tx_data),
    .empty     (tx_empty),
    .full      (tx_full),
    .count     (tx_count),
    .afull     (io_buffer_full)
  );

  logic unused_bits;
  assign unused_bits = ^{mem_a[31:18], tx_full, tx_count};

  assign mem_din      = (src_q == SRC_RAM) ? ram_rd_q : io_rd_q;
  assign tx_valid     = !tx_empty;
  assign rx_ready     = !rx_full_q;
  assign program_done = done_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Randomized + directed bench for mem_io_responder against a queue/array reference model.
module tb_mem_io_responder;

  localparam int TX_DEPTH = 16;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        program_done;

  mem_io_responder #(.RAM_ADDR_W(17), .TX_DEPTH(TX_DEPTH)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .mem_a          (mem_a),
    .mem_dout       (mem_dout),
    .mem_wr         (mem_wr),
    .mem_din        (mem_din),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .program_done   (program_done)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0]  ram_m [int];
  logic [7:0]  txq [$];
  bit          rx_has;
  logic [7:0]  rx_b;
  logic [31:0] cnt, snap;
  bit          done;
  logic [7:0]  exp_din;
  bit          din_known;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [17:0] a;
    bit          io, pre_rx, push;
    logic [7:0]  pb;
    a    = mem_a[17:0];
    io   = (a[17:16] == 2'b11);
    push = 0;
    pb   = 8'h00;
    if (rst_in) begin
      txq.delete();
      rx_has = 0; rx_b = 0; cnt = 0; snap = 0; done = 0;
      exp_din = 8'h00; din_known = 1;
      return;
    end
    pre_rx = rx_has;
    if (mem_wr) begin
      if (!io) ram_m[int'(a[16:0])] = mem_dout;
      else if (a == 18'h30000 && mem_dout != 8'h00) begin push = 1; pb = mem_dout; end
      else if (a == 18'h30004) begin push = 1; pb = 8'h00; done = 1; end
    end else if (!io) begin
      din_known = ram_m.exists(int'(a[16:0]));
      if (din_known) exp_din = ram_m[int'(a[16:0])];
    end else begin
      din_known = 1;
      case (a)
        18'h30000: begin exp_din = rx_has ? rx_b : 8'h00; rx_has = 0; end
        18'h30004: begin exp_din = cnt[7:0]; snap = cnt; end
        18'h30005: exp_din = snap[15:8];
        18'h30006: exp_din = snap[23:16];
        18'h30007: exp_din = snap[31:24];
        default:   exp_din = 8'h00;
      endcase
    end
    if (rx_valid && !pre_rx) begin rx_has = 1; rx_b = rx_data; end
    if (txq.size() > 0 && tx_ready) void'(txq.pop_front());
    if (push && txq.size() < TX_DEPTH) txq.push_back(pb);
    cnt = cnt + 1;
  endtask

  task automatic check_all();
    if (din_known) chk("mem_din", {24'h0, mem_din}, {24'h0, exp_din});
    chk("tx_valid", {31'h0, tx_valid}, {31'h0, txq.size() > 0});
    if (txq.size() > 0) chk("tx_data", {24'h0, tx_data}, {24'h0, txq[0]});
    chk("io_full", {31'h0, io_buffer_full}, {31'h0, txq.size() >= TX_DEPTH - 2});
    chk("rx_ready", {31'h0, rx_ready}, {31'h0, !rx_has});
    chk("done", {31'h0, program_done}, {31'h0, done});
  endtask

  task automatic step(input logic [31:0] a, input logic [7:0] d, input logic wr);
    mem_a = a; mem_dout = d; mem_wr = wr;
    model_edge();
    @(posedge clk_in);
    #1;
    check_all();
  endtask

  task automatic idle();
    step(32'h0003_0010, 8'h00, 1'b1);
  endtask

  task automatic do_reset();
    rst_in = 1'b1; rx_valid = 1'b0;
    repeat (3) step(32'h0, 8'h00, 1'b0);
    rst_in = 1'b0;
  endtask

  initial begin
    logic [31:0] r, a;
    int          op, rdy_pct;
    rst_in = 1'b1; mem_a = 0; mem_dout = 0; mem_wr = 0;
    tx_ready = 1'b0; rx_data = 0; rx_valid = 1'b0;
    rx_has = 0; rx_b = 0; cnt = 0; snap = 0; done = 0; exp_din = 0; din_known = 1;

    do_reset();
    chk("rst_din", {24'h0, mem_din}, 32'h0);
    chk("rst_rxrdy", {31'h0, rx_ready}, 32'h1);

    // RAM write then read-back
    step(32'h0000_0100, 8'h5A, 1'b1);
    step(32'h0000_0100, 8'h00, 1'b0);
    chk("ram5a", {24'h0, mem_din}, 32'h5A);

    // TX 'H','i',0x00
    step(32'h0003_0000, 8'h48, 1'b1);
    step(32'h0003_0000, 8'h69, 1'b1);
    step(32'h0003_0000, 8'h00, 1'b1);
    chk("tx_h", {24'h0, tx_data}, 32'h48);
    tx_ready = 1'b1;
    idle();
    chk("tx_i", {24'h0, tx_data}, 32'h69);
    idle();
    chk("tx_empty", {31'h0, tx_valid}, 32'h0);
    tx_ready = 1'b0;

    // Fill TX queue past almost-full and capacity
    for (int k = 1; k <= 17; k++) begin
      step(32'h0003_0000, 8'(k), 1'b1);
      if (k == 13) chk("afull13", {31'h0, io_buffer_full}, 32'h0);
      if (k == 14) chk("afull14", {31'h0, io_buffer_full}, 32'h1);
    end
    chk("fill_head", {24'h0, tx_data}, 32'h1);
    tx_ready = 1'b1;
    for (int k = 0; k < 16; k++) idle();
    chk("drain_empty", {31'h0, tx_valid}, 32'h0);
    tx_ready = 1'b0;

    // Counter snapshot 100 cycles after reset
    do_reset();
    for (int k = 0; k < 100; k++) idle();
    step(32'h0003_0004, 8'h00, 1'b0);
    chk("snap0", {24'h0, mem_din}, 32'h64);
    step(32'h0003_0005, 8'h00, 1'b0);
    chk("snap1", {24'h0, mem_din}, 32'h0);
    step(32'h0003_0006, 8'h00, 1'b0);
    chk("snap2", {24'h0, mem_din}, 32'h0);
    step(32'h0003_0007, 8'h00, 1'b0);
    chk("snap3", {24'h0, mem_din}, 32'h0);

    // RX capture and pop
    rx_data = 8'h41; rx_valid = 1'b1;
    idle();
    rx_valid = 1'b0;
    chk("rx_busy", {31'h0, rx_ready}, 32'h0);
    step(32'h0003_0000, 8'h00, 1'b0);
    chk("rx41", {24'h0, mem_din}, 32'h41);
    chk("rx_free", {31'h0, rx_ready}, 32'h1);
    step(32'h0003_0000, 8'h00, 1'b0);
    chk("rx_none", {24'h0, mem_din}, 32'h0);

    // Stop write and reset
    step(32'h0003_0004, 8'h77, 1'b1);
    chk("done_set", {31'h0, program_done}, 32'h1);
    chk("done_tx0", {24'h0, tx_data}, 32'h0);
    chk("done_txv", {31'h0, tx_valid}, 32'h1);
    do_reset();
    chk("done_rst", {31'h0, program_done}, 32'h0);
    chk("q_rst", {31'h0, tx_valid}, 32'h0);

    // Randomized traffic
    rdy_pct = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) rdy_pct = int'($urandom_range(0, 100));
      if (i == 1500) do_reset();
      tx_ready = ($urandom_range(0, 99) < rdy_pct);
      rx_valid = ($urandom_range(0, 3) == 0);
      rx_data  = 8'($urandom);
      r  = $urandom;
      op = int'($urandom_range(0, 9));
      a  = (r & 32'hFFFC_0000) | 32'h0000_0100 | (r & 32'h0000_000F) | (r & 32'h0001_0000);
      case (op)
        0, 1, 2: step(a, 8'($urandom), 1'b1);
        3, 4:    step(a, 8'h00, 1'b0);
        5:       step((r & 32'hFFFC_0000) | 32'h0003_0000,
                      ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom), 1'b1);
        6:       step((r & 32'hFFFC_0000) | 32'h0003_0000, 8'h00, 1'b0);
        7:       step(32'h0003_0004 + 32'($urandom_range(0, 3)), 8'h00, 1'b0);
        8:       step(32'h0003_0008 + 32'($urandom_range(0, 7)), 8'($urandom), r[0]);
        default: begin
          if ($urandom_range(0, 19) == 0) step(32'h0003_0004, 8'($urandom), 1'b1);
          else idle();
        end
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
